// File: rtl/imem_loader_fetch_if.sv
// Bus bundle for imem_loader_fetch: fetch port (PC/IF side) and byte-stream
// loader port (debug unit side). The optional readback pair is present only
// when IMEM_READBACK_EN is defined.
interface imem_loader_fetch_if #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 256
);
  localparam int CNTW = $clog2(CELDAS) + 1;

  // fetch port
  logic             i_Step;
  logic [NBITS-1:0] i_PC;
  logic [NBITS-1:0] o_Instruction;
  logic             o_InstrValid;
  logic             o_AddrFault;

  // loader port
  logic             i_LoadStart;
  logic [7:0]       i_LoadByte;
  logic             i_LoadValid;
  logic             o_LoadReady;
  logic             o_LoadDone;
  logic [CNTW-1:0]  o_LoadCount;

`ifdef IMEM_READBACK_EN
  logic [NBITS-1:0] i_DirecDebug;
  logic [NBITS-1:0] o_DatoDebug;
`endif

  // requester side: PC/IF stage plus debug unit
  modport master (
    output i_Step, i_PC, i_LoadStart, i_LoadByte, i_LoadValid,
    input  o_Instruction, o_InstrValid, o_AddrFault,
           o_LoadReady, o_LoadDone, o_LoadCount
`ifdef IMEM_READBACK_EN
    , output i_DirecDebug
    , input  o_DatoDebug
`endif
  );

  // memory side
  modport slave (
    input  i_Step, i_PC, i_LoadStart, i_LoadByte, i_LoadValid,
    output o_Instruction, o_InstrValid, o_AddrFault,
           o_LoadReady, o_LoadDone, o_LoadCount
`ifdef IMEM_READBACK_EN
    , input  i_DirecDebug
    , output o_DatoDebug
`endif
  );
endinterface

// File: rtl/imem_loader_fetch.sv
// imem_loader_fetch: instruction memory with a big-endian byte-stream loader
// and a synchronous, Step-gated, byte-addressed fetch port that flags
// misaligned and out-of-range addresses.
// Optional feature macro: IMEM_READBACK_EN (adds a word-indexed debug read port).
module imem_loader_fetch #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 256,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  imem_loader_fetch_if.slave    bus
);

  localparam int NBYTES = NBITS / 8;
  localparam int OFFW   = $clog2(NBYTES);   // byte-offset bits inside a word
  localparam int PTRW   = $clog2(CELDAS);   // word-address bits
  localparam int CNTW   = PTRW + 1;         // must hold CELDAS itself
  localparam int BCW    = (OFFW < 1) ? 1 : OFFW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Contents start at zero and survive reset; only the loader writes them.
  logic [NBITS-1:0] mem [CELDAS] = '{default: '0};

  logic [PTRW-1:0]   ptr_q;     // next word to write
  logic [BCW-1:0]    bcnt_q;    // bytes already held in asm_q
  logic [NBITS-9:0]  asm_q;     // partial word; last byte arrives straight from the bus
  logic [CNTW-1:0]   cnt_q;     // words written by this load

  logic              accept;
  logic              last_byte;
  logic              wr_en;
  logic              enter_load;
  logic              fetch;
  logic [NBITS-1:0]  word_full;

  logic [NBITS-1:0]  idx;
  logic              misal;
  logic              oor;
  logic [PTRW-1:0]   rd_addr;

  // Loader handshake and word completion
  always_comb begin
    accept     = (state_q == LOAD) && bus.i_LoadValid;
    last_byte  = (bcnt_q == BCW'(NBYTES - 1));
    wr_en      = accept && last_byte;
    word_full  = {asm_q, bus.i_LoadByte};
    enter_load = (state_q != LOAD) && bus.i_LoadStart;
    fetch      = (state_q != LOAD) && bus.i_Step;
  end

  // Fetch address decode: word index, misalignment, range
  always_comb begin
    idx     = bus.i_PC >> OFFW;
    misal   = |bus.i_PC[OFFW-1:0];
    oor     = (idx >> PTRW) != '0;
    rd_addr = idx[PTRW-1:0];
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; LoadStart is only honoured outside LOAD
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.i_LoadStart) state_d = LOAD;
      LOAD: begin
        // a full table ends the load just like the terminator word
        if (wr_en && ((word_full == HALT_WORD) || (ptr_q == PTRW'(CELDAS - 1))))
          state_d = DONE;
      end
      DONE: if (bus.i_LoadStart) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Loader status outputs decode directly from state
  assign bus.o_LoadReady = (state_q == LOAD);
  assign bus.o_LoadDone  = (state_q == DONE);
  assign bus.o_LoadCount = cnt_q;

  // Byte packer: shift bytes in MSB-first, advance pointer per completed word
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q  <= '0;
      bcnt_q <= '0;
      asm_q  <= '0;
      cnt_q  <= '0;
    end else if (enter_load) begin
      ptr_q  <= '0;
      bcnt_q <= '0;
      asm_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      if (last_byte) begin
        bcnt_q <= '0;
        asm_q  <= '0;
        ptr_q  <= ptr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
        asm_q  <= word_full[NBITS-9:0];
      end
    end
  end

  // Memory write port; writes only happen in LOAD, so never alongside a fetch
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[ptr_q] <= word_full;
  end

  // Fetch port: one-cycle latency, bad addresses return a NOP with a fault flag
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bus.o_Instruction <= '0;
      bus.o_AddrFault   <= 1'b0;
      bus.o_InstrValid  <= 1'b0;
    end else begin
      bus.o_InstrValid <= fetch;
      if (fetch) begin
        if (misal || oor) begin
          bus.o_Instruction <= '0;
          bus.o_AddrFault   <= 1'b1;
        end else begin
          bus.o_Instruction <= mem[rd_addr];
          bus.o_AddrFault   <= 1'b0;
        end
      end
    end
  end

`ifdef IMEM_READBACK_EN
  logic dbg_oor;
  logic [PTRW-1:0] dbg_addr;

  // Debug index decode
  always_comb begin
    dbg_oor  = (bus.i_DirecDebug >> PTRW) != '0;
    dbg_addr = bus.i_DirecDebug[PTRW-1:0];
  end

  // Debug readback: free-running, any state, zero outside the table
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     bus.o_DatoDebug <= '0;
    else if (dbg_oor) bus.o_DatoDebug <= '0;
    else              bus.o_DatoDebug <= mem[dbg_addr];
  end
`endif

endmodule

// File: tb/tb_imem_loader_fetch.sv
// Randomised scoreboard bench for imem_loader_fetch. A transaction-level model
// (word array + byte queue) predicts fetch results and loader status; a
// separate monitor pops predicted fetches whenever o_InstrValid is seen.
module tb_imem_loader_fetch;
  localparam int          NBITS  = 32;
  localparam int          CELDAS = 256;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_fetch_if #(.NBITS(NBITS), .CELDAS(CELDAS)) bus();

  imem_loader_fetch #(.NBITS(NBITS), .CELDAS(CELDAS), .HALT_WORD(HALT)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } fexp_t;

  int          checks   = 0;
  int          failures = 0;
  fexp_t       exp_q[$];
  logic [31:0] model_mem [CELDAS];
  bit          m_loading;
  bit          m_done;
  int          m_ptr;
  int          m_count;
  logic [7:0]  m_bytes[$];
  logic [31:0] exp_dbg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fexp_t fetch_ref(input logic [31:0] pc);
    fexp_t r;
    if ((pc % 4) != 0 || (pc / 4) >= CELDAS) begin
      r.instr = 32'h0;
      r.fault = 1'b1;
    end else begin
      r.instr = model_mem[pc / 4];
      r.fault = 1'b0;
    end
    return r;
  endfunction

  // One clock of stimulus: check status from the previous edge, drive inputs,
  // then advance the model to what the coming edge should do.
  task automatic cycle(input bit step, input logic [31:0] pc, input bit start,
                       input bit valid, input logic [7:0] b);
    logic [31:0] w;
`ifdef IMEM_READBACK_EN
    int unsigned dbg;
`endif
    @(negedge clk);
    chk("load_ready", 64'(bus.o_LoadReady), 64'(m_loading));
    chk("load_done",  64'(bus.o_LoadDone),  64'(m_done));
    chk("load_count", 64'(bus.o_LoadCount), 64'(m_count));
`ifdef IMEM_READBACK_EN
    chk("dato_debug", 64'(bus.o_DatoDebug), 64'(exp_dbg));
    dbg = $urandom_range(0, CELDAS + 15);
    bus.i_DirecDebug = 32'(dbg);
    exp_dbg = (dbg < CELDAS) ? model_mem[dbg] : 32'h0;
`endif
    bus.i_Step      = step;
    bus.i_PC        = pc;
    bus.i_LoadStart = start;
    bus.i_LoadValid = valid;
    bus.i_LoadByte  = b;
    if (!m_loading) begin
      if (step) exp_q.push_back(fetch_ref(pc));
      if (start) begin
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_ptr     = 0;
        m_count   = 0;
        m_bytes.delete();
      end
    end else if (valid) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        model_mem[m_ptr] = w;
        m_ptr++;
        m_count++;
        m_bytes.delete();
        if (w == HALT || m_ptr == CELDAS) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fetch(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 1'b0, 8'h00);
  endtask

  // Send one word MSB byte first; with gaps, idle cycles carry random
  // Step/LoadStart noise that the loader must ignore.
  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0)
          cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
      cycle(1'b0, 32'h0, 1'b0, 1'b1, w[31-8*i -: 8]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_Step = 1'b0; bus.i_PC = 32'h0; bus.i_LoadStart = 1'b0;
    bus.i_LoadValid = 1'b0; bus.i_LoadByte = 8'h0;
`ifdef IMEM_READBACK_EN
    bus.i_DirecDebug = 32'h0;
`endif
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_count   = 0;
    m_bytes.delete();
    repeat (2) @(negedge clk);
    chk("rst_instr",  64'(bus.o_Instruction), 64'h0);
    chk("rst_valid",  64'(bus.o_InstrValid),  64'h0);
    chk("rst_fault",  64'(bus.o_AddrFault),   64'h0);
    chk("rst_ready",  64'(bus.o_LoadReady),   64'h0);
    chk("rst_done",   64'(bus.o_LoadDone),    64'h0);
    chk("rst_count",  64'(bus.o_LoadCount),   64'h0);
`ifdef IMEM_READBACK_EN
    chk("rst_dbg",    64'(bus.o_DatoDebug),   64'h0);
`endif
    #2;
    rst_n = 1'b1;
    exp_dbg = model_mem[0];
  endtask

  // Monitor: pops a prediction per valid pulse, otherwise checks outputs hold
  initial begin
    fexp_t       e;
    logic [31:0] held_i;
    logic        held_f;
    held_i = 32'h0;
    held_f = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_i = 32'h0;
        held_f = 1'b0;
      end else if (bus.o_InstrValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected_valid actual=1 expected=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_instr", 64'(bus.o_Instruction), 64'(e.instr));
          chk("fetch_fault", 64'(bus.o_AddrFault),   64'(e.fault));
          held_i = e.instr;
          held_f = e.fault;
        end
      end else begin
        chk("hold_instr", 64'(bus.o_Instruction), 64'(held_i));
        chk("hold_fault", 64'(bus.o_AddrFault),   64'(held_f));
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] pc;
    int          nw;
    int          n;
    for (int i = 0; i < CELDAS; i++) model_mem[i] = 32'h0;
    exp_dbg = 32'h0;
    do_reset();

    // directed load: two words then terminator
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    send_word(32'h0022_0820, 1'b0);
    send_word(32'hABCD_EF01, 1'b0);
    send_word(HALT, 1'b0);
    idle();
    chk("t1_done",  64'(bus.o_LoadDone),  64'h1);
    chk("t1_count", 64'(bus.o_LoadCount), 64'd3);
    chk("t1_ready", 64'(bus.o_LoadReady), 64'h0);

    // aligned fetches, then hold
    fetch(32'd4);
    repeat (3) idle();
    fetch(32'd0);
    fetch(32'd8);
    idle();

    // misaligned and out of range
    fetch(32'd6);
    fetch(32'd1024);
    idle();
    fetch(32'd1020);

    // reset in the middle of the second word
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    send_word(32'h1122_3344, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'h55);
    cycle(1'b1, 32'h0, 1'b1, 1'b1, 8'h66);  // Step and LoadStart ignored in LOAD
    do_reset();
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'd8);
    idle();

    // randomised loads and fetches
    for (int r = 0; r < 10; r++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 1023), 1'b1, 1'b0, 8'h00);
      nw = $urandom_range(1, 20);
      for (int k = 0; k < nw; k++) send_word($urandom & 32'h7FFF_FFFF, 1'b1);
      send_word(HALT, 1'b1);
      // a byte offered in DONE is dropped
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'($urandom));
      for (int k = 0; k < 25; k++) begin
        case ($urandom_range(0, 3))
          0, 1: pc = 32'($urandom_range(0, CELDAS - 1)) * 4;
          2:    pc = 32'($urandom_range(0, CELDAS - 1)) * 4 + 32'($urandom_range(1, 3));
          default: pc = $urandom;
        endcase
        if ($urandom_range(0, 2) == 0) idle();
        else fetch(pc);
      end
    end

    // full-table load with no terminator
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < CELDAS; k++) begin
      w = $urandom & 32'h7FFF_FFFF;
      send_word(w, 1'b0);
    end
    idle();
    chk("t4_done",  64'(bus.o_LoadDone),  64'h1);
    chk("t4_count", 64'(bus.o_LoadCount), 64'd256);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'hEE);
    fetch(32'd0);
    fetch(32'd1020);
    fetch(32'd512);
    idle();

    // drain outstanding predictions
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
